// File: rtl/stream_packetizer.sv
// stream_packetizer: reads NSAMP 16-bit samples from a synchronous buffer and
// frames them for the UART TX as
//   SYNC0, SYNC1, count[15:8], count[7:0], samples (big-endian), CSUM
// over a valid/ready byte interface. CSUM is the mod-256 sum of the count and
// payload bytes; the sync bytes are not included.
module stream_packetizer #(
    parameter int         NSAMP  = 256,
    parameter int         ADDR_W = 8,
    parameter logic [7:0] SYNC0  = 8'hA5,
    parameter logic [7:0] SYNC1  = 8'h5A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    // The index is one bit wider than the address so it can reach NSAMP.
    localparam int              IW       = ADDR_W + 1;
    localparam logic [15:0]     COUNT    = 16'(NSAMP);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NSAMP - 1);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_S0    = 4'd1,
        ST_S1    = 4'd2,
        ST_CH    = 4'd3,
        ST_CL    = 4'd4,
        ST_FETCH = 4'd5,
        ST_WAIT  = 4'd6,
        ST_DH    = 4'd7,
        ST_DL    = 4'd8,
        ST_CSUM  = 4'd9,
        ST_DONE  = 4'd10
    } state_t;

    state_t            state_r;
    logic [IW-1:0]     idx_r;
    logic [7:0]        acc_r;
    logic [15:0]       hold_r;
    logic              busy_r;
    logic              done_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [7:0]        tx_data_r;
    logic              tx_valid_r;

    logic              xfer_s;
    logic [IW-1:0]     idx_inc_s;

    // Running checksum step: plain 8-bit wrap-around addition.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        csum_add = acc + b;
    endfunction

    assign xfer_s    = tx_valid_r & tx_ready;
    assign idx_inc_s = idx_r + IDX_ONE;

    // Framing FSM: sequences header, sample fetches, payload and checksum bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            acc_r      <= 8'h00;
            hold_r     <= 16'h0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_addr_r  <= '0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_S0;
                        idx_r      <= '0;
                        acc_r      <= 8'h00;
                        busy_r     <= 1'b1;
                        tx_valid_r <= 1'b1;
                        tx_data_r  <= SYNC0;
                    end
                end
                ST_S0: begin
                    if (xfer_s) begin
                        state_r   <= ST_S1;
                        tx_data_r <= SYNC1;
                    end
                end
                ST_S1: begin
                    if (xfer_s) begin
                        state_r   <= ST_CH;
                        tx_data_r <= COUNT[15:8];
                    end
                end
                ST_CH: begin
                    if (xfer_s) begin
                        state_r   <= ST_CL;
                        acc_r     <= csum_add(acc_r, COUNT[15:8]);
                        tx_data_r <= COUNT[7:0];
                    end
                end
                ST_CL: begin
                    if (xfer_s) begin
                        state_r    <= ST_FETCH;
                        acc_r      <= csum_add(acc_r, COUNT[7:0]);
                        tx_valid_r <= 1'b0;
                        rd_addr_r  <= idx_r[ADDR_W-1:0];
                    end
                end
                ST_FETCH: begin
                    // Address is already on rd_addr; the buffer answers next cycle.
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_r    <= ST_DH;
                    hold_r     <= rd_data;
                    tx_valid_r <= 1'b1;
                    tx_data_r  <= rd_data[15:8];
                end
                ST_DH: begin
                    if (xfer_s) begin
                        state_r   <= ST_DL;
                        acc_r     <= csum_add(acc_r, hold_r[15:8]);
                        tx_data_r <= hold_r[7:0];
                    end
                end
                ST_DL: begin
                    if (xfer_s) begin
                        idx_r <= idx_inc_s;
                        acc_r <= csum_add(acc_r, hold_r[7:0]);
                        // Compare the pre-increment index so the last sample
                        // flows straight into the checksum byte.
                        if (idx_r < LAST_IDX) begin
                            state_r    <= ST_FETCH;
                            tx_valid_r <= 1'b0;
                            rd_addr_r  <= idx_inc_s[ADDR_W-1:0];
                        end else begin
                            state_r   <= ST_CSUM;
                            tx_data_r <= csum_add(acc_r, hold_r[7:0]);
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer_s) begin
                        state_r    <= ST_DONE;
                        tx_valid_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    tx_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_addr  = rd_addr_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;

endmodule

// File: tb/tb_stream_packetizer.sv
// Bench for stream_packetizer: two instances (NSAMP=4 and NSAMP=256) against
// a frame-level model that knows the byte list of a frame and how many idle
// cycles precede each byte.
module tb_stream_packetizer;

    typedef logic [7:0] bq_t[$];
    typedef logic [15:0] sq_t[$];

    typedef struct {
        bit         busy;
        bit         done;
        bit         stall;
        int         pos;
        int         gap;
        int         start_cyc;
        int         stalls;
        int         frames;
        int         lat;
        logic [7:0] hold;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Instance A: 4 samples
    logic        a_start = 1'b0, a_ready = 1'b0;
    logic        a_busy, a_done, a_valid;
    logic [1:0]  a_rd_addr;
    logic [15:0] a_rd_data;
    logic [7:0]  a_data;
    logic [15:0] mem_a [4];

    // Instance B: 256 samples
    logic        b_start = 1'b0, b_ready = 1'b0;
    logic        b_busy, b_done, b_valid;
    logic [7:0]  b_rd_addr;
    logic [15:0] b_rd_data;
    logic [7:0]  b_data;
    logic [15:0] mem_b [256];

    bq_t  exp_a, exp_b;
    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};
    logic [7:0] last_b_addr = 8'd0;
    int   b_addr_moves = 0;

    always #5 clk = ~clk;

    // Cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous read buffers: data one cycle after the address
    always @(posedge clk) begin
        a_rd_data <= mem_a[a_rd_addr];
        b_rd_data <= mem_b[b_rd_addr];
    end

    stream_packetizer #(.NSAMP(4), .ADDR_W(2)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .tx_data(a_data),
        .tx_valid(a_valid), .tx_ready(a_ready)
    );

    stream_packetizer #(.NSAMP(256), .ADDR_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .tx_data(b_data),
        .tx_valid(b_valid), .tx_ready(b_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame as the host sees it: sync, count, big-endian samples, sum of non-sync bytes
    function automatic bq_t build_frame(input int n, input sq_t s);
        bq_t f;
        logic [7:0]  sum;
        logic [15:0] cnt;
        logic [15:0] smp;
        sum = 8'h00;
        cnt = 16'(n);
        f.push_back(8'hA5);
        f.push_back(8'h5A);
        f.push_back(cnt[15:8]);
        f.push_back(cnt[7:0]);
        for (int i = 0; i < n; i++) begin
            smp = s[i];
            f.push_back(smp[15:8]);
            f.push_back(smp[7:0]);
        end
        for (int i = 2; i < f.size(); i++) sum = sum + f[i];
        f.push_back(sum);
        return f;
    endfunction

    // One cycle of the frame model: compare, then advance to next-cycle expectations.
    // Bytes are sent back to back, except each sample's high byte is preceded by
    // two idle cycles (buffer read); one done cycle follows the checksum byte.
    task automatic mdl_step(input string tag, inout mdl_t m, input logic busy,
                            input logic done, input logic valid, input logic [7:0] data,
                            input logic start, input logic ready, input int nsamp,
                            input bq_t exp);
        int len;
        bit ev;
        len = exp.size();
        if (!rst) begin
            chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
            chk({tag, "_rst_done"}, 32'(done), 32'd0);
            chk({tag, "_rst_valid"}, 32'(valid), 32'd0);
            m.busy = 1'b0; m.done = 1'b0; m.stall = 1'b0; m.pos = 0; m.gap = 0;
        end else begin
            ev = m.busy && (m.gap == 0);
            chk({tag, "_busy"}, 32'(busy), 32'(m.busy));
            chk({tag, "_done"}, 32'(done), 32'(m.done));
            chk({tag, "_valid"}, 32'(valid), 32'(ev));
            if (ev) chk({tag, "_byte"}, 32'(data), 32'(exp[m.pos]));
            if (m.stall) chk({tag, "_stable"}, 32'({valid, data}), 32'({1'b1, m.hold}));
            m.stall = ev && !ready;
            if (ev) m.hold = exp[m.pos];
            if (m.done) begin
                m.done = 1'b0;
                m.frames++;
                m.lat = cyc - m.start_cyc + 1;
                chk({tag, "_latency"}, 32'(m.lat), 32'(4 * nsamp + 7 + m.stalls));
            end else if (!m.busy) begin
                if (start) begin
                    m.busy = 1'b1; m.pos = 0; m.gap = 0; m.stalls = 0;
                    m.start_cyc = cyc;
                end
            end else if (m.gap > 0) begin
                m.gap--;
            end else if (ready) begin
                if (m.pos == len - 1) begin
                    m.busy = 1'b0;
                    m.done = 1'b1;
                end else begin
                    m.pos++;
                    m.gap = (m.pos >= 4 && m.pos < len - 1 && (m.pos % 2) == 0) ? 2 : 0;
                end
            end else begin
                m.stalls++;
            end
        end
    endtask

    // Compare process: both instances against the model every cycle
    always @(negedge clk) begin
        mdl_step("a", ma, a_busy, a_done, a_valid, a_data, a_start, a_ready, 4, exp_a);
        if (rst && mb.busy && b_rd_addr != last_b_addr) begin
            chk("b_rd_addr_step", 32'(b_rd_addr), 32'(8'(last_b_addr + 8'd1)));
            b_addr_moves++;
        end
        last_b_addr = b_rd_addr;
        mdl_step("b", mb, b_busy, b_done, b_valid, b_data, b_start, b_ready, 256, exp_b);
    end

    task automatic pulse_a_start();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic wait_a_frames(input int target, input string name);
        for (int k = 0; k < 400 && ma.frames < target; k++) begin
            @(posedge clk); #1;
        end
        chk(name, 32'(ma.frames), 32'(target));
    endtask

    initial begin : main
        sq_t sa, sb;
        logic [7:0] lit_a [13];
        lit_a = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h10, 8'h00, 8'h10, 8'h01,
                  8'h10, 8'h02, 8'h10, 8'h03, 8'h4A};
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 16'h1000 + 16'(i);
            sa.push_back(mem_a[i]);
        end
        for (int i = 0; i < 256; i++) begin
            mem_b[i] = 16'h1000 + 16'(i);
            sb.push_back(mem_b[i]);
        end
        exp_a = build_frame(4, sa);
        exp_b = build_frame(256, sb);

        // Hand-computed pins on the model
        chk("model_a_len", 32'(exp_a.size()), 32'd13);
        for (int i = 0; i < 13; i++) chk("model_a_byte", 32'(exp_a[i]), 32'(lit_a[i]));
        chk("model_b_len", 32'(exp_b.size()), 32'd517);
        chk("model_b_cnt_hi", 32'(exp_b[2]), 32'h01);
        chk("model_b_cnt_lo", 32'(exp_b[3]), 32'h00);
        chk("model_b_csum", 32'(exp_b[516]), 32'h81);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_txdata", 32'(a_data), 32'h00);
        chk("rst_a_rdaddr", 32'(a_rd_addr), 32'd0);
        chk("rst_b_txdata", 32'(b_data), 32'h00);
        chk("rst_b_rdaddr", 32'(b_rd_addr), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Long frame with ready tied high
        b_ready = 1'b1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int k = 0; k < 1200 && mb.frames < 1; k++) begin
            @(posedge clk); #1;
        end
        chk("b_frame_done", 32'(mb.frames), 32'd1);
        chk("b_latency_lit", 32'(mb.lat), 32'd1031);
        chk("b_addr_moves", 32'(b_addr_moves), 32'd255);

        // Short frame, ready tied high
        a_ready = 1'b1;
        pulse_a_start();
        wait_a_frames(1, "a_frame1_done");
        chk("a_latency_lit", 32'(ma.lat), 32'd23);

        // Random backpressure
        a_start = 1'b1;
        for (int k = 0; k < 400 && ma.frames < 2; k++) begin
            @(posedge clk); #1;
            a_start = 1'b0;
            a_ready = 1'($urandom_range(0, 1));
        end
        chk("a_frame2_done", 32'(ma.frames), 32'd2);
        a_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Extra starts during DH of sample 0 and during CSUM are ignored
        pulse_a_start();
        for (int k = 0; k < 400 && ma.frames < 3; k++) begin
            a_start = 1'(ma.busy && ma.gap == 0 && (ma.pos == 4 || ma.pos == 12));
            @(posedge clk); #1;
        end
        a_start = 1'b0;
        chk("a_frame3_done", 32'(ma.frames), 32'd3);
        repeat (20) @(posedge clk);
        #1;
        chk("a_no_extra_frame", 32'(ma.frames), 32'd3);

        // Reset during DL of sample 2
        pulse_a_start();
        for (int k = 0; k < 100 && !(ma.busy && ma.gap == 0 && ma.pos == 9); k++) begin
            @(posedge clk); #1;
        end
        chk("a_reached_dl2", 32'(ma.pos), 32'd9);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(a_busy), 32'd0);
        chk("midrst_done", 32'(a_done), 32'd0);
        chk("midrst_valid", 32'(a_valid), 32'd0);
        chk("midrst_txdata", 32'(a_data), 32'h00);
        chk("midrst_rdaddr", 32'(a_rd_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("a_no_partial_frame", 32'(ma.frames), 32'd3);
        pulse_a_start();
        wait_a_frames(4, "a_frame_after_rst");

        // Start held high: back-to-back frames
        a_start = 1'b1;
        for (int k = 0; k < 400 && ma.frames < 7; k++) begin
            @(posedge clk); #1;
        end
        a_start = 1'b0;
        chk("a_back_to_back", 32'(ma.frames), 32'd7);
        repeat (10) @(posedge clk);
        #1;
        chk("a_idle_after_hold", 32'(ma.frames), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_packetizer.md
# stream_packetizer

Framing stage between the 16-bit sample buffer and the UART transmitter in `top_fpga_dsp`. On a start pulse it reads NSAMP samples from the buffer's read port and emits a byte frame over a valid/ready byte interface to the UART TX. The frame is sync word, sample count, big-endian sample payload, then an 8-bit additive checksum. The host-side capture script parses this frame directly.

## Interface
- `NSAMP`, 256, samples per frame; 1..65535.
- `ADDR_W`, 8, buffer address width; 2^ADDR_W >= NSAMP.
- `SYNC0`, 8'hA5, first sync byte.
- `SYNC1`, 8'h5A, second sync byte.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; synchronous deassert handled externally.
- `start`  in  1  frame request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted start until the last byte is accepted.
- `done`  out  1  one-cycle pulse after the checksum byte is accepted.
- `rd_addr`  out  ADDR_W  buffer read address.
- `rd_data`  in  16  buffer read data; valid exactly 1 cycle after `rd_addr`.
- `tx_data`  out  8  byte to UART TX.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  UART TX accepts the byte; a transfer occurs when `tx_valid & tx_ready` at a rising edge.

## Operation
- Frame byte order:
  - `SYNC0`, `SYNC1`
  - NSAMP[15:8], NSAMP[7:0]
  - for i = 0..NSAMP-1: sample[i][15:8], sample[i][7:0]
  - CSUM
- Frame length is 5 + 2*NSAMP bytes.
- CSUM is the 8-bit sum (mod 256) of every byte after `SYNC1`: both count bytes and all payload bytes. Sync bytes are excluded.
- Accumulator: 8-bit; cleared on start; updated when a count or payload byte transfers.
- Sample index: ADDR_W+1 bits wide, so it reaches NSAMP without wrap. `rd_addr` = index[ADDR_W-1:0].
- FSM states and transitions:
  - IDLE: on `start` -> S0.
  - S0 -> S1 -> CH -> CL, each on transfer.
  - CL -> FETCH on transfer.
  - FETCH: drive `rd_addr` -> WAIT.
  - WAIT: latch `rd_data` into a 16-bit holding register -> DH.
  - DH -> DL on transfer.
  - DL on transfer: increment index; -> FETCH if index+1 < NSAMP, else CSUM.
  - CSUM on transfer -> DONE.
  - DONE: pulse `done`; -> IDLE.
- `tx_valid` is high in S0, S1, CH, CL, DH, DL and CSUM; low in IDLE, FETCH, WAIT and DONE.
- While `tx_valid` is high, `tx_data` is held stable until the transfer; the block never withdraws `tx_valid` before the transfer.
- `start` is ignored outside IDLE. A `start` held high through DONE launches a new frame from IDLE on the next cycle.
- `tx_ready` is ignored when `tx_valid` is low.
- Reset mid-frame aborts immediately, with no partial checksum. The next start begins a fresh frame.

## Timing
- Reset values: `busy`=0, `done`=0, `tx_valid`=0, `tx_data`=8'h00, `rd_addr`=0. State=IDLE, index=0, accumulator=0, holding register=0.
- `start` accepted at edge N: S0 with `tx_valid`=1, `tx_data`=`SYNC0` and `busy`=1 from N+1.
- With `tx_ready` tied high:
  - header bytes: 1 per cycle;
  - each sample: 4 cycles (FETCH, WAIT, DH, DL);
  - frame total: 4*NSAMP + 7 cycles from start to the `done` pulse.
- `busy` falls in the cycle `done` is asserted.
- The index compare uses the pre-increment value, so there is no extra cycle at the frame end.
- Backpressure: each cycle `tx_ready` is low extends the current byte by one cycle, with no other state change.

## Test plan
- NSAMP=4, buffer {1000,1001,1002,1003}, `tx_ready`=1 -> bytes A5 5A 00 04 10 00 10 01 10 02 10 03 4A; `done` pulses 23 cycles after start.
- NSAMP=256, buffer 16'h1000+i -> 517 bytes; count bytes 01 00; CSUM=8'h81; `rd_addr` sweeps 0..255 once, in order.
- NSAMP=4, `tx_ready` toggling pseudo-randomly -> byte stream identical to the first scenario; `tx_data` never changes while `tx_valid`=1 and `tx_ready`=0.
- Second `start` pulses during DH and CSUM -> ignored: a single 13-byte frame and a single `done`.
- `rst` asserted while in DL of sample 2 -> all outputs at reset values within the same cycle; a following start yields a complete, correct 13-byte frame.
- `start` held high continuously -> back-to-back frames, each beginning with A5 one cycle after the `done` cycle.
